// File: rtl/rr_grant_arbiter_8.sv
// Eight-way round-robin arbiter with bounded hold time.
// Grants are registered and published as one-hot plus binary index.
module rr_grant_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam logic [3:0] MaxHoldCnt = 4'(MAX_HOLD);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] cur_q, cur_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       preempt_q, preempt_d;

  logic [7:0] others;
  logic [3:0] win_req, win_oth;
  logic       new_grant;
  logic [2:0] new_idx;

  // Returns {found, index} of the first set bit scanning start, start+1, ... modulo 8.
  function automatic logic [3:0] find_first(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] idx;
    logic [3:0] res;
    res = 4'd0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!res[3] && mask[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign others  = req & ~(8'd1 << cur_q);
  assign win_req = find_first(req, ptr_q);
  assign win_oth = find_first(others, ptr_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    cur_d       = cur_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    new_grant   = 1'b0;
    new_idx     = 3'd0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          new_grant = 1'b1;
          new_idx   = win_req[2:0];
        end
      end
      StGrant: begin
        if (!req[cur_q]) begin
          // Release wins over hold expiry, so no preempt here.
          if (|others) begin
            new_grant = 1'b1;
            new_idx   = win_oth[2:0];
          end else begin
            state_d     = StIdle;
            hold_cnt_d  = 4'd0;
            gnt_d       = 8'd0;
            gnt_id_d    = 3'd0;
            gnt_valid_d = 1'b0;
          end
        end else if (|others && hold_cnt_q >= MaxHoldCnt) begin
          new_grant = 1'b1;
          new_idx   = win_oth[2:0];
          preempt_d = 1'b1;
        end else if (hold_cnt_q < MaxHoldCnt) begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (new_grant) begin
      state_d     = StGrant;
      cur_d       = new_idx;
      ptr_d       = new_idx + 3'd1;
      hold_cnt_d  = 4'd1;
      gnt_d       = 8'd1 << new_idx;
      gnt_id_d    = new_idx;
      gnt_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= 4'd0;
      cur_q       <= 3'd0;
      gnt_q       <= 8'd0;
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      cur_q       <= cur_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter_8.sv
// Directed-vector bench for rr_grant_arbiter_8 with MAX_HOLD = 4.
module tb_rr_grant_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  rr_grant_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".gnt"}, 32'(gnt), 32'h0);
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'h0);
    check({tag, ".valid"}, 32'(gnt_valid), 32'h0);
    check({tag, ".preempt"}, 32'(preempt), 32'h0);
  endtask

  task automatic expect_grant(input string tag, input int id, input bit pre);
    check({tag, ".gnt"}, 32'(gnt), 32'h1 << id);
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
    check({tag, ".valid"}, 32'(gnt_valid), 32'h1);
    check({tag, ".preempt"}, 32'(preempt), 32'(pre));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;

    // Reset held with all requests active.
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_idle("reset");
    end
    rst_n = 1'b1;

    // Full contention: each requester held 4 cycles, preempt on every handover.
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        expect_grant("contend", g % 8, (c == 0) && (g != 0));
      end
    end
    req = 8'h00;
    tick();
    expect_idle("contend_drop");

    // Single requester 5; no combinational path from req.
    req = 8'h20;
    #1;
    expect_idle("no_comb");
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_grant("single", 5, 1'b0);
    end
    req = 8'h00;
    tick();
    expect_idle("single_drop");

    // Serve 7 so the pointer wraps to 0.
    req = 8'h80;
    tick();
    expect_grant("serve7", 7, 1'b0);
    req = 8'h00;
    tick();
    expect_idle("serve7_drop");

    // Wrap-around picks 0 first, then back-to-back release hands over to 7.
    req = 8'h81;
    tick();
    expect_grant("wrap0", 0, 1'b0);
    tick();
    expect_grant("wrap0_hold", 0, 1'b0);
    req = 8'h80;
    tick();
    expect_grant("b2b", 7, 1'b0);
    req = 8'h00;
    tick();
    expect_idle("b2b_drop");

    // Pointer now at 0 after serving 7: 3 beats 7.
    req = 8'h88;
    tick();
    expect_grant("wrap3", 3, 1'b0);
    req = 8'h00;
    tick();
    expect_idle("wrap3_drop");

    // Reset mid-grant of requester 6; next search starts at 0.
    req = 8'h40;
    tick();
    expect_grant("grant6", 6, 1'b0);
    rst_n = 1'b0;
    req   = 8'hFF;
    tick();
    expect_idle("mid_reset");
    rst_n = 1'b1;
    tick();
    expect_grant("post_reset", 0, 1'b0);

    // Release coinciding with hold expiry is a plain release.
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_grant("hold0", 0, 1'b0);
    end
    req = 8'hFE;
    tick();
    expect_grant("rel_expiry", 1, 1'b0);

    req = 8'h00;
    tick();
    expect_idle("final_drop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
